// File: rtl/serv_immdec_par_if.sv
// Fetch-side bundle for serv_immdec_par: instruction load strobe/payload, beat advance,
// and the decoded register addresses plus the serial immediate stream.
interface serv_immdec_par_if #(
    parameter int unsigned W = 1
);
    logic          i_wb_en;
    logic [24:0]   i_wb_rdt;
    logic [2:0]    i_fmt;
    logic          i_cnt_en;
    logic [4:0]    o_rd_addr;
    logic [4:0]    o_rs1_addr;
    logic [4:0]    o_rs2_addr;
    logic [W-1:0]  o_imm;
    logic          o_imm_busy;
    logic          o_imm_last;
    logic [W-1:0]  o_csr_imm;

    modport master (
        output i_wb_en, i_wb_rdt, i_fmt, i_cnt_en,
        input  o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm, o_imm_busy, o_imm_last, o_csr_imm
    );

    modport slave (
        input  i_wb_en, i_wb_rdt, i_fmt, i_cnt_en,
        output o_rd_addr, o_rs1_addr, o_rs2_addr, o_imm, o_imm_busy, o_imm_last, o_csr_imm
    );
endinterface

// File: rtl/serv_immdec_par.sv
// Parametrised SERV immediate/register-address decoder: latches rs1/rs2/rd and the RV32I
// immediate on fetch, then streams it LSB-first W bits per beat. Optional SERV_IMMDEC_CSR_IMM_EN.
module serv_immdec_par #(
    parameter int unsigned W         = 1,
    parameter bit          SIGN_HOLD = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    serv_immdec_par_if.slave bus
);
    localparam int unsigned NB = 32 / W;
    localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

    logic [31:7]   ins;
    logic [31:0]   imm32;

    logic [4:0]    rd_q,   rd_d;
    logic [4:0]    rs1_q,  rs1_d;
    logic [4:0]    rs2_q,  rs2_d;
    logic [31:0]   sreg_q, sreg_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          fill_q, fill_d;
    logic          busy_q, busy_d;
    logic          last_c;
`ifdef SERV_IMMDEC_CSR_IMM_EN
    logic [4:0]    zimm_q, zimm_d;
    logic [31:0]   zword;
`endif

    assign ins = bus.i_wb_rdt;

    // RV32I immediate formats; reserved encodings (and zimm when the CSR path is absent) give 0
    always_comb begin
        imm32 = '0;
        case (bus.i_fmt)
            3'd0:    imm32 = {{21{ins[31]}}, ins[30:20]};
            3'd1:    imm32 = {{21{ins[31]}}, ins[30:25], ins[11:7]};
            3'd2:    imm32 = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3:    imm32 = {ins[31:12], 12'b0};
            3'd4:    imm32 = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
`ifdef SERV_IMMDEC_CSR_IMM_EN
            3'd5:    imm32 = {27'b0, ins[19:15]};
`endif
            default: imm32 = '0;
        endcase
    end

    assign last_c = busy_q && (cnt_q == CW'(NB - 1));

    // Load has priority over a beat; a beat only counts while a stream is in flight
    always_comb begin
        rd_d   = rd_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        fill_d = fill_q;
        busy_d = busy_q;
`ifdef SERV_IMMDEC_CSR_IMM_EN
        zimm_d = zimm_q;
`endif
        if (bus.i_wb_en) begin
            rd_d   = ins[11:7];
            rs1_d  = ins[19:15];
            rs2_d  = ins[24:20];
            sreg_d = imm32;
            cnt_d  = '0;
            fill_d = imm32[31];
            busy_d = 1'b1;
`ifdef SERV_IMMDEC_CSR_IMM_EN
            zimm_d = ins[19:15];
`endif
        end else if (bus.i_cnt_en && busy_q) begin
            sreg_d = {{W{fill_q}}, sreg_q[31:W]};
            if (last_c) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            sreg_q <= '0;
            cnt_q  <= '0;
            fill_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef SERV_IMMDEC_CSR_IMM_EN
            zimm_q <= '0;
`endif
        end else begin
            rd_q   <= rd_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            fill_q <= fill_d;
            busy_q <= busy_d;
`ifdef SERV_IMMDEC_CSR_IMM_EN
            zimm_q <= zimm_d;
`endif
        end
    end

    assign bus.o_rd_addr  = rd_q;
    assign bus.o_rs1_addr = rs1_q;
    assign bus.o_rs2_addr = rs2_q;
    assign bus.o_imm_busy = busy_q;
    assign bus.o_imm_last = last_c;
    assign bus.o_imm      = busy_q    ? sreg_q[W-1:0] :
                            SIGN_HOLD ? {W{fill_q}}   : '0;

`ifdef SERV_IMMDEC_CSR_IMM_EN
    // zimm beat selected by the shared counter rather than a second shift register
    assign zword         = {27'b0, zimm_q};
    assign bus.o_csr_imm = busy_q ? W'(zword >> (32'(cnt_q) * W)) : '0;
`else
    assign bus.o_csr_imm = '0;
`endif

endmodule

// File: tb/tb_serv_immdec_par.sv
// Directed bench for serv_immdec_par at W=4 (sign hold), W=1 (sign hold) and W=8 (zero idle).
module tb_serv_immdec_par;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    serv_immdec_par_if #(.W(4)) if4 ();
    serv_immdec_par_if #(.W(1)) if1 ();
    serv_immdec_par_if #(.W(8)) if8 ();

    serv_immdec_par #(.W(4), .SIGN_HOLD(1'b1)) u_dut4 (.i_clk(clk), .i_rst(rst), .bus(if4));
    serv_immdec_par #(.W(1), .SIGN_HOLD(1'b1)) u_dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    serv_immdec_par #(.W(8), .SIGN_HOLD(1'b0)) u_dut8 (.i_clk(clk), .i_rst(rst), .bus(if8));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic load4(input logic [31:0] instr, input logic [2:0] fmt, input logic ce);
        @(negedge clk);
        if4.i_wb_en  = 1'b1;
        if4.i_wb_rdt = instr[31:7];
        if4.i_fmt    = fmt;
        if4.i_cnt_en = ce;
    endtask

    task automatic load1(input logic [31:0] instr, input logic [2:0] fmt);
        @(negedge clk);
        if1.i_wb_en  = 1'b1;
        if1.i_wb_rdt = instr[31:7];
        if1.i_fmt    = fmt;
        if1.i_cnt_en = 1'b0;
    endtask

    task automatic load8(input logic [31:0] instr, input logic [2:0] fmt);
        @(negedge clk);
        if8.i_wb_en  = 1'b1;
        if8.i_wb_rdt = instr[31:7];
        if8.i_fmt    = fmt;
        if8.i_cnt_en = 1'b0;
    endtask

    task automatic run4(input int n, output logic [31:0] w, output logic [31:0] cw,
                        output logic [31:0] lm, output logic [31:0] bm);
        w = '0; cw = '0; lm = '0; bm = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w[k*4 +: 4]  = if4.o_imm;
            cw[k*4 +: 4] = if4.o_csr_imm;
            lm[k]        = if4.o_imm_last;
            bm[k]        = if4.o_imm_busy;
            if4.i_wb_en  = 1'b0;
            if4.i_cnt_en = 1'b1;
        end
    endtask

    task automatic run1(input int n, output logic [31:0] w, output logic [31:0] lm,
                        output logic [31:0] bm);
        w = '0; lm = '0; bm = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w[k]         = if1.o_imm[0];
            lm[k]        = if1.o_imm_last;
            bm[k]        = if1.o_imm_busy;
            if1.i_wb_en  = 1'b0;
            if1.i_cnt_en = 1'b1;
        end
    endtask

    task automatic run8(input int n, output logic [31:0] w, output logic [31:0] lm,
                        output logic [31:0] bm);
        w = '0; lm = '0; bm = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            w[k*8 +: 8]  = if8.o_imm;
            lm[k]        = if8.o_imm_last;
            bm[k]        = if8.o_imm_busy;
            if8.i_wb_en  = 1'b0;
            if8.i_cnt_en = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] w, cw, lm, bm;

        if4.i_wb_en = 1'b0; if4.i_wb_rdt = '0; if4.i_fmt = '0; if4.i_cnt_en = 1'b0;
        if1.i_wb_en = 1'b0; if1.i_wb_rdt = '0; if1.i_fmt = '0; if1.i_cnt_en = 1'b0;
        if8.i_wb_en = 1'b0; if8.i_wb_rdt = '0; if8.i_fmt = '0; if8.i_cnt_en = 1'b0;

        // reset state
        #2;
        chk("rst_imm4",  32'(if4.o_imm), 32'h0);
        chk("rst_busy4", 32'(if4.o_imm_busy), 32'h0);
        chk("rst_last4", 32'(if4.o_imm_last), 32'h0);
        chk("rst_rs1_4", 32'(if4.o_rs1_addr), 32'h0);
        chk("rst_imm1",  32'(if1.o_imm), 32'h0);
        chk("rst_imm8",  32'(if8.o_imm), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // addi x1,x2,-1, W=4
        load4(32'hFFF10093, 3'd0, 1'b0);
        run4(8, w, cw, lm, bm);
        chk("t1_word", w, 32'hFFFFFFFF);
        chk("t1_last", lm, 32'h80);
        chk("t1_busy", bm, 32'hFF);
`ifdef SERV_IMMDEC_CSR_IMM_EN
        chk("t1_csr", cw, 32'h2);
`else
        chk("t1_csr", cw, 32'h0);
`endif
        chk("t1_rd",  32'(if4.o_rd_addr),  32'd1);
        chk("t1_rs1", 32'(if4.o_rs1_addr), 32'd2);
        chk("t1_rs2", 32'(if4.o_rs2_addr), 32'd31);
        @(negedge clk);
        chk("t1_idle_busy", 32'(if4.o_imm_busy), 32'h0);
        chk("t1_idle_imm",  32'(if4.o_imm), 32'hF);
        repeat (3) @(negedge clk);
        chk("t1_idle_last", 32'(if4.o_imm_last), 32'h0);
        if4.i_cnt_en = 1'b0;

        // beq x0,x0,-4, W=1
        load1(32'hFE000EE3, 3'd2);
        run1(32, w, lm, bm);
        chk("t2_word", w, 32'hFFFFFFFC);
        chk("t2_b01",  32'(w[1:0]), 32'h0);
        chk("t2_last", lm, 32'h80000000);
        chk("t2_busy", bm, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t2_idle_imm",  32'(if1.o_imm), 32'h1);
        chk("t2_idle_busy", 32'(if1.o_imm_busy), 32'h0);
        if1.i_cnt_en = 1'b0;

        // lui x1,0x12345, W=8, zero idle
        load8(32'h123450B7, 3'd3);
        run8(4, w, lm, bm);
        chk("t3_word", w, 32'h12345000);
        chk("t3_last", lm, 32'h8);
        chk("t3_busy", bm, 32'hF);
        chk("t3_rd",   32'(if8.o_rd_addr), 32'd1);
        @(negedge clk);
        chk("t3_idle_imm", 32'(if8.o_imm), 32'h0);
        if8.i_cnt_en = 1'b0;
        load8(32'hFFF10093, 3'd0);
        run8(4, w, lm, bm);
        chk("t3i_word", w, 32'hFFFFFFFF);
        @(negedge clk);
        chk("t3i_idle_imm", 32'(if8.o_imm), 32'h0);
        if8.i_cnt_en = 1'b0;

        // csrrwi x0,mstatus,0x1F, W=4
        load4(32'h300FD073, 3'd5, 1'b0);
        run4(8, w, cw, lm, bm);
`ifdef SERV_IMMDEC_CSR_IMM_EN
        chk("t4_word", w,  32'h1F);
        chk("t4_csr",  cw, 32'h1F);
`else
        chk("t4_word", w,  32'h0);
        chk("t4_csr",  cw, 32'h0);
`endif
        chk("t4_last", lm, 32'h80);
        @(negedge clk);
        chk("t4_idle_imm", 32'(if4.o_imm), 32'h0);

        // sw x5,8(x2) with a beat request in the load cycle, then reload mid-stream
        load4(32'h00512423, 3'd1, 1'b1);
        run4(8, w, cw, lm, bm);
        chk("t5_word", w, 32'h00000008);
        chk("t5_last", lm, 32'h80);
        chk("t5_rs2",  32'(if4.o_rs2_addr), 32'd5);
        load4(32'h00512423, 3'd1, 1'b1);
        run4(3, w, cw, lm, bm);
        chk("t5_part", w, 32'h00000008);
        load4(32'h00512423, 3'd1, 1'b1);
        run4(8, w, cw, lm, bm);
        chk("t5r_word", w, 32'h00000008);
        chk("t5r_last", lm, 32'h80);
        chk("t5r_busy", bm, 32'hFF);

        // async reset on beat 3 of the addi stream
        load4(32'hFFF10093, 3'd0, 1'b0);
        run4(3, w, cw, lm, bm);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_imm",  32'(if4.o_imm), 32'h0);
        chk("t6_busy", 32'(if4.o_imm_busy), 32'h0);
        chk("t6_last", 32'(if4.o_imm_last), 32'h0);
        chk("t6_rd",   32'(if4.o_rd_addr), 32'h0);
        chk("t6_rs1",  32'(if4.o_rs1_addr), 32'h0);
        chk("t6_rs2",  32'(if4.o_rs2_addr), 32'h0);
        chk("t6_csr",  32'(if4.o_csr_imm), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_idle_busy", 32'(if4.o_imm_busy), 32'h0);
        chk("t6_idle_imm",  32'(if4.o_imm), 32'h0);
        load4(32'hFFF10093, 3'd0, 1'b0);
        run4(8, w, cw, lm, bm);
        chk("t6_word", w, 32'hFFFFFFFF);
        chk("t6_rlast", lm, 32'h80);
        if4.i_cnt_en = 1'b0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
